// File: rtl/seq_shifter.sv
// Sequential bit-serial shifter: captures an operand, shifts it one bit per
// cycle in the selected mode, and registers the final value on completion.
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   amt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] M_LSR = 2'b00;
  localparam logic [1:0] M_ASR = 2'b01;
  localparam logic [1:0] M_LSL = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  logic [1:0]       state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] work;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] stepped;

  // ASR replicates the working MSB; under ASR that bit never changes, so it
  // always equals the captured operand MSB.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                              input logic [1:0]       m);
    logic [WIDTH-1:0] r;
    r = v;
    case (m)
      M_LSR:   r = {1'b0, v[WIDTH-1:1]};
      M_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
      M_LSL:   r = {v[WIDTH-2:0], 1'b0};
      M_ROR:   r = {v[0], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb stepped = shift1(work, mode_q);

  // NOTE: every register here is small control/datapath state, so all of it
  // is reset; nonblocking assignments keep each edge's updates simultaneous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      work   <= '0;
      mode_q <= M_LSR;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            work   <= a;
            mode_q <= mode;
            cnt    <= amt;
            if (amt != '0) begin
              state <= S_SHIFT;
            end else begin
              result <= a;
              state  <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          work <= stepped;
          cnt  <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            result <= stepped;
            state  <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter (WIDTH=8): per-cycle busy/done
// timing, final results, input isolation while busy, reset abort, start held.
module tb_seq_shifter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [2:0] amt;
  logic [1:0] mode;
  logic       busy;
  logic       done;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_result;

  seq_shifter #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .amt    (amt),
    .mode   (mode),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge during IDLE; the next posedge is the start edge.
  // While the op runs, operands are scrambled and start is kept high so any
  // leakage of live inputs into the operation shows up in the result.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [2:0] am,
                        input logic [1:0] md, input logic [7:0] exp, input bit hold);
    a = av; amt = am; mode = md; start = 1'b1;
    for (int c = 1; c <= int'(am) + 1; c++) begin
      @(negedge clk);
      a = ~av; amt = am ^ 3'h5; mode = ~md;
      start = hold || (c <= int'(am));
      check({tag, "_busy"}, busy, (c <= int'(am)));
      check({tag, "_done"}, done, (c == int'(am) + 1));
      if (c <= int'(am)) check({tag, "_hold_result"}, result, exp_result);
    end
    check({tag, "_result"}, result, exp);
    exp_result = exp;
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_done"}, done, 1'b0);
    check({tag, "_idle_result"}, result, exp);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = 8'h00; amt = 3'd0; mode = 2'b00;
    exp_result = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'h00);
    rst_n = 1'b1;

    run_op("lsr3", 8'hB4, 3'd3, 2'b00, 8'h16, 1'b0);
    run_op("asr2", 8'h96, 3'd2, 2'b01, 8'hE5, 1'b0);
    run_op("lsl1", 8'h5B, 3'd1, 2'b10, 8'hB6, 1'b0);
    run_op("ror4", 8'h81, 3'd4, 2'b11, 8'h18, 1'b0);
    run_op("amt0", 8'h3C, 3'd0, 2'b11, 8'h3C, 1'b0);
    run_op("lsr7", 8'hFF, 3'd7, 2'b00, 8'h01, 1'b0);
    run_op("asr3neg", 8'h80, 3'd3, 2'b01, 8'hF0, 1'b0);
    run_op("lsl7", 8'hFF, 3'd7, 2'b10, 8'h80, 1'b0);

    // Reset two cycles into a 5-bit shift: outputs clear at once, no done.
    a = 8'hAA; amt = 3'd5; mode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_c1", busy, 1'b1);
    @(negedge clk);
    check("abort_busy_c2", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", result, 8'h00);
    exp_result = 8'h00;
    @(negedge clk);
    check("abort_done_held", done, 1'b0);
    rst_n = 1'b1;
    // First edge after reset release accepts a new start.
    run_op("post_rst_ror1", 8'h01, 3'd1, 2'b11, 8'h80, 1'b0);

    // start held high through a chain of back-to-back operations.
    run_op("hold_a", 8'hC3, 3'd2, 2'b00, 8'h30, 1'b1);
    run_op("hold_b", 8'h0F, 3'd0, 2'b10, 8'h0F, 1'b1);
    run_op("hold_c", 8'h92, 3'd1, 2'b01, 8'hC9, 1'b1);
    run_op("hold_d", 8'h12, 3'd3, 2'b11, 8'h42, 1'b1);
    start = 1'b0;
    @(negedge clk);
    check("final_idle_busy", busy, 1'b0);
    check("final_result", result, 8'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
